// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO: pops a programmed burst
// and re-presents it on a registered valid/ready stream.
module fifo_rd_stream #(
  parameter int DSIZE   = 8,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic [DSIZE-1:0]   rdata,
  input  logic               rempty,
  output logic               rinc,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic [DSIZE-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_W-1:0]   rd_count
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_t;

  state_t             state;
  logic [BURST_W-1:0] remaining;
  logic [1:0]         occ;
  logic [DSIZE-1:0]   tail;
  logic               xfer;

  // Pop only from registered state and rempty; m_ready never reaches rinc.
  assign rinc = !rrst && (state == BURST) &&
                (remaining != '0) && !rempty &&
                (occ != 2'd2);

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid && m_ready;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              remaining <= burst_len;
              busy      <= 1'b1;
              state     <= BURST;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (rinc) remaining <= remaining - 1'b1;
          if (remaining == '0) state <= FLUSH;
        end
        FLUSH: begin
          if (occ == 2'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // m_data is the head slot; tail holds the second word when occ==2.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ      <= 2'd0;
      m_data   <= '0;
      tail     <= '0;
      rd_count <= '0;
    end else begin
      if (rinc) rd_count <= rd_count + 1'b1;
      unique case ({rinc, xfer})
        2'b10: begin
          if (occ == 2'd0) m_data <= rdata;
          else             tail   <= rdata;
          occ <= occ + 1'b1;
        end
        2'b01: begin
          if (occ == 2'd2) m_data <= tail;
          occ <= occ - 1'b1;
        end
        2'b11: m_data <= rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, stream monitor
// and per-scenario tasks.
module tb_fifo_rd_stream;

  localparam logic [7:0] PAT [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] PAT5 [5] =
    '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy;
  logic        done;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] rd_count;

  int n_chk = 0;
  int n_fail = 0;
  int npop = 0;
  int ndone = 0;
  int viol = 0;
  int occ_m = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d = 8'd0;
  logic [15:0] rd_exp = 16'd0;

  logic [7:0] fq[$];
  logic [7:0] wq[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  fifo_rd_stream #(
    .DSIZE(8),
    .BURST_W(8),
    .CNT_W(16)
  ) dut (
    .rclk(rclk),
    .rrst(rrst),
    .rdata(rdata),
    .rempty(rempty),
    .rinc(rinc),
    .start(start),
    .burst_len(burst_len),
    .busy(busy),
    .done(done),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .rd_count(rd_count)
  );

  always #5 rclk = ~rclk;

  // Show-ahead FIFO: pop on rinc, writes land at the edge after request.
  always @(posedge rclk) begin
    if (rinc && !rempty && fq.size() > 0) void'(fq.pop_front());
    while (wq.size() > 0) fq.push_back(wq.pop_front());
    rempty <= (fq.size() == 0);
    rdata  <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Stream monitor: occupancy model, hold stability, pop/done tallies.
  always @(negedge rclk) begin
    if (rrst) begin
      occ_m <= 0;
      hold  <= 1'b0;
    end else begin
      if ((m_valid !== (occ_m != 0)) ||
          (rinc && occ_m == 2) ||
          (rinc && rempty) ||
          (hold && (!m_valid || m_data !== hold_d)))
        viol <= viol + 1;
      hold   <= m_valid && !m_ready;
      hold_d <= m_data;
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (rinc && !rempty) npop <= npop + 1;
      if (done) ndone <= ndone + 1;
      occ_m <= occ_m + int'(rinc && !rempty)
                     - int'(m_valid && m_ready);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic kick(input logic [7:0] len);
    start     = 1'b1;
    burst_len = len;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge rclk);
      if (done === 1'b1) ok = 1'b1;
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset;
    rrst = 1'b1;
    cyc(2);
    @(negedge rclk);
    n_chk++;
    if (rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rinc_in: got %0b want 0", rinc);
    end
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    rd_exp = 16'd0;
    @(negedge rclk);
    n_chk++;
    if ({m_valid, busy, done, rinc} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got v%0b b%0b d%0b r%0b want 0",
               m_valid, busy, done, rinc);
    end
    n_chk++;
    if (rd_count !== 16'd0 || m_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got cnt %0h data %0h want 0",
               rd_count, m_data);
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic test_basic;
    int p0, d0;
    bit ok;
    got_q.delete();
    p0 = npop;
    d0 = ndone;
    for (int i = 0; i < 4; i++) wq.push_back(PAT[i]);
    cyc(2);
    m_ready = 1'b1;
    kick(8'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      n_chk++;
      if (rinc !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_rinc[%0d]: got %0b want 1", i, rinc);
      end
      if (i > 0) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_data !== PAT[i-1]) begin
          n_fail++;
          $display("FAIL basic_lat[%0d]: got v%0b %0h want 1 %0h",
                   i, m_valid, m_data, PAT[i-1]);
        end
      end
    end
    wait_done(50, ok);
    rd_exp = rd_exp + 16'd4;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done: got timeout want done");
    end
    n_chk++;
    if (rd_count !== rd_exp || npop - p0 != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d pops %0d want %0d",
               rd_count, npop - p0, rd_exp);
    end
    n_chk++;
    if (ndone - d0 != 1 || rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_end: got dones %0d empty %0b want 1 1",
               ndone - d0, rempty);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== PAT[i]) begin
        n_fail++;
        $display("FAIL basic_data[%0d]: got %0h want %0h",
                 i, got_q[i], PAT[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int p0, d0;
    bit ok;
    got_q.delete();
    p0 = npop;
    d0 = ndone;
    for (int i = 0; i < 4; i++) wq.push_back(PAT[i]);
    cyc(2);
    m_ready = 1'b0;
    kick(8'd4);
    cyc(10);
    n_chk++;
    if (npop - p0 != 2) begin
      n_fail++;
      $display("FAIL bp_pops: got %0d want 2", npop - p0);
    end
    @(negedge rclk);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 8'h11 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got v%0b %0h b%0b want 1 11 1",
               m_valid, m_data, busy);
    end
    @(posedge rclk);
    #1;
    m_ready = 1'b1;
    wait_done(50, ok);
    rd_exp = rd_exp + 16'd4;
    n_chk++;
    if (!ok || ndone - d0 != 1 || rd_count !== rd_exp) begin
      n_fail++;
      $display("FAIL bp_done: got ok%0b dones %0d cnt %0d want 1 1 %0d",
               ok, ndone - d0, rd_count, rd_exp);
    end
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL bp_len: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== PAT[i]) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %0h want %0h",
                 i, got_q[i], PAT[i]);
      end
    end
  endtask

  task automatic test_underflow;
    int p0, d0, bad;
    bit ok;
    got_q.delete();
    p0 = npop;
    d0 = ndone;
    bad = 0;
    m_ready = 1'b1;
    wq.push_back(8'hA1);
    cyc(2);
    kick(8'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (busy !== 1'b1 || (rempty && rinc)) bad++;
    end
    @(posedge rclk);
    #1;
    n_chk++;
    if (npop - p0 != 1) begin
      n_fail++;
      $display("FAIL uf_pops: got %0d want 1", npop - p0);
    end
    wq.push_back(8'hA2);
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      if (busy !== 1'b1 || (rempty && rinc)) bad++;
    end
    @(posedge rclk);
    #1;
    n_chk++;
    if (ndone - d0 != 0) begin
      n_fail++;
      $display("FAIL uf_early: got dones %0d want 0", ndone - d0);
    end
    wq.push_back(8'hA3);
    wait_done(50, ok);
    rd_exp = rd_exp + 16'd3;
    n_chk++;
    if (!ok || bad != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_stall: got ok%0b bad %0d busy %0b want 1 0 0",
               ok, bad, busy);
    end
    n_chk++;
    if (got_q.size() != 3 || got_q[0] !== 8'hA1 ||
        got_q[1] !== 8'hA2 || got_q[2] !== 8'hA3) begin
      n_fail++;
      $display("FAIL uf_data: got n%0d %0h %0h %0h want 3 a1 a2 a3",
               got_q.size(), got_q[0], got_q[1], got_q[2]);
    end
  endtask

  task automatic test_zero_ignore;
    int p0, d0, bad;
    bit ok;
    p0 = npop;
    d0 = ndone;
    bad = 0;
    kick(8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      if (busy !== 1'b0 || rinc !== 1'b0) bad++;
    end
    @(posedge rclk);
    #1;
    n_chk++;
    if (ndone - d0 != 1 || npop - p0 != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL zero_len: got dones %0d pops %0d bad %0d want 1 0 0",
               ndone - d0, npop - p0, bad);
    end
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      wq.push_back(v);
      exp_q.push_back(v);
    end
    m_ready = 1'b0;
    cyc(2);
    kick(8'd4);
    cyc(3);
    kick(8'd9);
    m_ready = 1'b1;
    wait_done(60, ok);
    cyc(15);
    rd_exp = rd_exp + 16'd4;
    n_chk++;
    if (!ok || ndone - d0 != 2 || npop - p0 != 4) begin
      n_fail++;
      $display("FAIL ign_start: got ok%0b dones %0d pops %0d want 1 2 4",
               ok, ndone - d0, npop - p0);
    end
    n_chk++;
    if (got_q != exp_q || rd_count !== rd_exp) begin
      n_fail++;
      $display("FAIL ign_data: got n%0d cnt %0d want n4 cnt %0d",
               got_q.size(), rd_count, rd_exp);
    end
  endtask

  task automatic test_mid_reset;
    int cnt;
    bit ok;
    got_q.delete();
    for (int i = 0; i < 5; i++) wq.push_back(PAT5[i]);
    cyc(2);
    m_ready = 1'b1;
    kick(8'd5);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge rclk);
      if (rinc && !rempty) cnt++;
    end
    @(posedge rclk);
    #1;
    rrst = 1'b1;
    cyc(1);
    rrst = 1'b0;
    rd_exp = 16'd0;
    @(negedge rclk);
    n_chk++;
    if ({m_valid, busy, rinc} !== 3'b000 || rd_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mrst_state: got v%0b b%0b r%0b cnt %0d want 0",
               m_valid, busy, rinc, rd_count);
    end
    @(posedge rclk);
    #1;
    got_q.delete();
    kick(8'd3);
    wait_done(50, ok);
    rd_exp = 16'd3;
    n_chk++;
    if (!ok || got_q.size() != 3 || got_q[0] !== 8'h33 ||
        got_q[1] !== 8'h44 || got_q[2] !== 8'h55) begin
      n_fail++;
      $display("FAIL mrst_next: got ok%0b n%0d %0h want 1 3 33",
               ok, got_q.size(), got_q[0]);
    end
    n_chk++;
    if (rd_count !== rd_exp) begin
      n_fail++;
      $display("FAIL mrst_cnt: got %0d want %0d", rd_count, rd_exp);
    end
  endtask

  task automatic test_soak;
    for (int b = 0; b < 6; b++) begin
      int p0, d0, nw, nbad;
      bit ok;
      logic [7:0] len;
      len = (b == 0) ? 8'd255 : 8'($urandom_range(1, 255));
      got_q.delete();
      exp_q.delete();
      p0 = npop;
      d0 = ndone;
      nw = 0;
      ok = 1'b0;
      kick(len);
      for (int c = 0; c < 4000 && !ok; c++) begin
        if (nw < int'(len) && $urandom_range(0, 3) != 0) begin
          logic [7:0] v;
          v = 8'($urandom);
          wq.push_back(v);
          exp_q.push_back(v);
          nw++;
        end
        m_ready = ($urandom_range(0, 2) != 0);
        @(negedge rclk);
        if (done === 1'b1) ok = 1'b1;
        @(posedge rclk);
        #1;
      end
      m_ready = 1'b1;
      rd_exp = rd_exp + 16'(len);
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
      n_chk++;
      if (!ok || got_q.size() != int'(len) || nbad != 0) begin
        n_fail++;
        $display("FAIL soak_data[%0d]: got ok%0b n%0d bad %0d want n%0d",
                 b, ok, got_q.size(), nbad, len);
      end
      n_chk++;
      if (rd_count !== rd_exp || npop - p0 != int'(len) ||
          ndone - d0 != 1) begin
        n_fail++;
        $display("FAIL soak_cnt[%0d]: got %0d dones %0d want %0d 1",
                 b, rd_count, ndone - d0, rd_exp);
      end
    end
  endtask

  task automatic test_monitor;
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL stream_rules: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_zero_ignore();
    test_mid_reset();
    test_soak();
    test_monitor();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's dual-clock FIFO. Lives entirely in the read clock domain.
- Drains a programmed number of words from the FIFO's show-ahead read port (rdata, rempty, rinc) and presents them on a registered valid/ready stream toward downstream logic.
- A 2-entry output buffer decouples m_ready from rinc, so there is no combinational path from m_ready to rinc.
- Burst control is a small state machine with start/busy/done handshake and a running pop counter for scoreboarding.

Parameters:
- DSIZE, 8: data width; must match the FIFO's DSIZE.
- BURST_W, 8: width of burst_len and of the remaining-word counter.
- CNT_W, 16: width of rd_count.

Ports:
- rclk, input, 1: read-domain clock, rising edge.
- rrst, input, 1: synchronous, active-high reset.
- rdata, input, DSIZE: FIFO head word; valid whenever rempty=0.
- rempty, input, 1: FIFO empty flag.
- rinc, output, 1: FIFO pop strobe; the FIFO advances at the rclk edge when rinc=1 and rempty=0.
- start, input, 1: single-cycle request to begin a burst.
- burst_len, input, BURST_W: number of words to pop; sampled only on an accepted start.
- busy, output, 1: high from an accepted start until done.
- done, output, 1: one-cycle pulse when a burst completes.
- m_data, output, DSIZE: stream data.
- m_valid, output, 1: stream valid.
- m_ready, input, 1: downstream ready.
- rd_count, output, CNT_W: total pops since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset: sampled on the rclk edge when rrst=1. Clears state to IDLE, remaining=0, occ=0, rd_count=0, busy=0, done=0, m_valid=0, m_data=0.
  - rinc is 0 during reset and in the cycle after it.
  - Reset mid-burst discards buffered words. The FIFO itself is not reset by this block.
- States:
  - IDLE:
    - start=1 with burst_len!=0: remaining<=burst_len, go to BURST, busy<=1.
    - start=1 with burst_len=0: done<=1 on the next edge, stay IDLE, busy stays 0, no pops.
  - BURST: pops until remaining=0, then go to FLUSH.
  - FLUSH: wait until occ=0 (all words accepted downstream), then done<=1, busy<=0, go to IDLE.
  - start outside IDLE is ignored; burst_len is not resampled.
- Pop rule:
  - rinc = (state==BURST) && (remaining!=0) && !rempty && (occ<2).
  - rinc is built only from registered state and rempty; it never depends on m_ready.
  - On a pop edge: rdata is written to the buffer tail, remaining decrements, rd_count increments.
- Output buffer: 2-entry FIFO with occupancy occ in 0..2.
  - m_valid = (occ!=0). m_data = head entry, registered.
  - A transfer occurs when m_valid && m_ready; the head advances.
  - Pop and transfer in the same cycle leave occ unchanged, giving 1 word/cycle sustained throughput.
  - Word order is preserved exactly as popped.
- Latency: a word popped at edge N is visible on m_data/m_valid after edge N (first cycle following the pop) when occ was 0.
- Boundaries:
  - rempty rising mid-burst: rinc drops the same cycle and the burst stalls in BURST with no timeout; it resumes when rempty falls.
  - m_ready=0 for a long time: occ saturates at 2 and rinc holds 0.
  - m_valid/m_data stay stable while m_valid=1 and m_ready=0.
  - burst_len = 2^BURST_W-1 is supported; remaining never underflows.
  - rd_count wraps from 2^CNT_W-1 to 0.
  - done asserts exactly once per accepted start and is never asserted together with a new busy rise in the same cycle.

Test Plan:
- Basic burst: FIFO preloaded with 0x11,0x22,0x33,0x44; start with burst_len=4, m_ready=1 -> four consecutive rinc cycles; m_data 0x11..0x44 on consecutive cycles; done pulses once; rd_count=4; FIFO left empty.
- Backpressure: same preload, m_ready=0 for 10 cycles then 1 -> exactly 2 pops before the stall, m_data holds 0x11 stable, remaining words follow in order, no loss or duplication.
- Underflow stall: burst_len=3, FIFO holds 1 word, second word written 20 cycles later, third 5 cycles after that -> rinc is 0 while rempty=1; busy stays 1 throughout; done only after the third word is accepted.
- Zero length and ignored start: burst_len=0 -> done pulses with no rinc and busy=0; a start pulse during an active burst -> no effect on remaining or on the done count.
- Mid-burst reset: rrst=1 for 1 cycle after 2 of 5 pops -> next cycle m_valid=0, busy=0, rd_count=0, rinc=0; a new burst then pops the FIFO's next word, 0x33.
- Random soak: random m_ready, random writer rate, random burst_len up to 255 -> scoreboard matches FIFO write order; rd_count equals the sum of burst_len values; never rinc=1 while occ=2.
